// File: rtl/exec_unit.sv
// Execute/writeback stage: reads two registers, runs the ALU or an
// iterative shifter, then writes the result and Z/C/N flags back.
module exec_unit #(
    parameter int WORD_SIZE = 16,
    parameter int COUNT = 32,
    localparam int COUNT_BITS = $clog2(COUNT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [3:0]            op,
    input  logic [COUNT_BITS-1:0] idx_x,
    input  logic [COUNT_BITS-1:0] idx_y,
    input  logic [3:0]            imm,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [COUNT_BITS-1:0] reg_idx_a,
    output logic [COUNT_BITS-1:0] reg_idx_b,
    input  logic [WORD_SIZE-1:0]  reg_data_a,
    input  logic [WORD_SIZE-1:0]  reg_data_b,
    output logic [WORD_SIZE-1:0]  wr_data,
    output logic [COUNT_BITS-1:0] wr_idx,
    output logic                  wr_en,
    output logic                  flag_z,
    output logic                  flag_c,
    output logic                  flag_n
);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_ADC = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_CMP = 4'd6;
    localparam logic [3:0] OP_MOV = 4'd7;
    localparam logic [3:0] OP_INC = 4'd8;
    localparam logic [3:0] OP_DEC = 4'd9;
    localparam logic [3:0] OP_SHR = 4'd10;
    localparam logic [3:0] OP_SHL = 4'd11;

    localparam logic [WORD_SIZE:0] ONE = {{WORD_SIZE{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_SHIFT,
        S_WB
    } state_t;

    state_t               state;
    logic [3:0]           op_q;
    logic [3:0]           imm_q;
    logic [3:0]           cnt;
    logic [WORD_SIZE-1:0] op_a;
    logic [WORD_SIZE-1:0] op_b;

    logic [WORD_SIZE:0]   sum;
    logic [WORD_SIZE-1:0] alu_res;
    logic                 alu_c;
    logic                 alu_wr;
    logic                 alu_fl;
    logic                 alu_ill;
    logic                 is_shift;
    logic                 shl;
    logic [WORD_SIZE-1:0] sh_res;
    logic                 sh_c;

    assign is_shift = (op_q == OP_SHR) || (op_q == OP_SHL);
    assign shl      = (op_q == OP_SHL);

    always_comb begin
        sum     = '0;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_wr  = 1'b1;
        alu_fl  = 1'b1;
        alu_ill = 1'b0;
        case (op_q)
            OP_ADD: sum = {1'b0, op_a} + {1'b0, op_b};
            OP_ADC: sum = {1'b0, op_a} + {1'b0, op_b}
                        + {{WORD_SIZE{1'b0}}, flag_c};
            OP_SUB: sum = {1'b0, op_a} - {1'b0, op_b};
            OP_CMP: begin
                sum    = {1'b0, op_a} - {1'b0, op_b};
                alu_wr = 1'b0;
            end
            OP_AND: sum = {1'b0, op_a & op_b};
            OP_OR:  sum = {1'b0, op_a | op_b};
            OP_XOR: sum = {1'b0, op_a ^ op_b};
            OP_MOV: begin
                sum    = {1'b0, op_b};
                alu_fl = 1'b0;
            end
            OP_INC: sum = {1'b0, op_a} + ONE;
            OP_DEC: sum = {1'b0, op_a} - ONE;
            OP_SHR, OP_SHL: sum = {1'b0, op_a};
            default: begin
                alu_wr  = 1'b0;
                alu_fl  = 1'b0;
                alu_ill = 1'b1;
            end
        endcase
        alu_res = sum[WORD_SIZE-1:0];
        alu_c   = sum[WORD_SIZE];
    end

    // One bit per cycle; carry takes whichever bit falls off the end
    always_comb begin
        sh_res = shl ? {op_a[WORD_SIZE-2:0], 1'b0}
                     : {1'b0, op_a[WORD_SIZE-1:1]};
        sh_c   = shl ? op_a[WORD_SIZE-1] : op_a[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            op_q      <= '0;
            imm_q     <= '0;
            cnt       <= '0;
            op_a      <= '0;
            op_b      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            reg_idx_a <= '0;
            reg_idx_b <= '0;
            wr_data   <= '0;
            wr_idx    <= '0;
            wr_en     <= 1'b0;
            flag_z    <= 1'b0;
            flag_c    <= 1'b0;
            flag_n    <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q      <= op;
                        imm_q     <= imm;
                        reg_idx_a <= idx_x;
                        reg_idx_b <= idx_y;
                        busy      <= 1'b1;
                        state     <= S_READ;
                    end
                end
                S_READ: begin
                    op_a  <= reg_data_a;
                    op_b  <= reg_data_b;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    if (is_shift && imm_q != '0) begin
                        cnt   <= imm_q;
                        state <= S_SHIFT;
                    end else begin
                        done   <= 1'b1;
                        err    <= alu_ill;
                        wr_en  <= alu_wr;
                        if (alu_wr) begin
                            wr_data <= alu_res;
                            wr_idx  <= reg_idx_a;
                        end
                        if (alu_fl) begin
                            flag_z <= (alu_res == '0);
                            flag_c <= alu_c;
                            flag_n <= alu_res[WORD_SIZE-1];
                        end
                        state <= S_WB;
                    end
                end
                S_SHIFT: begin
                    op_a <= sh_res;
                    cnt  <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        done    <= 1'b1;
                        wr_en   <= 1'b1;
                        wr_data <= sh_res;
                        wr_idx  <= reg_idx_a;
                        flag_z  <= (sh_res == '0);
                        flag_c  <= sh_c;
                        flag_n  <= sh_res[WORD_SIZE-1];
                        state   <= S_WB;
                    end
                end
                S_WB: begin
                    done  <= 1'b0;
                    err   <= 1'b0;
                    wr_en <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exec_unit.sv
// Bench for exec_unit: register file model, directed commands and a
// scoreboard monitor that checks every done/wr_en pulse.
module tb_exec_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  op = '0;
    logic [4:0]  idx_x = '0;
    logic [4:0]  idx_y = '0;
    logic [3:0]  imm = '0;
    logic        busy, done, err, wr_en;
    logic [4:0]  reg_idx_a, reg_idx_b, wr_idx;
    logic [15:0] reg_data_a, reg_data_b, wr_data;
    logic        flag_z, flag_c, flag_n;

    logic [15:0] rf [32];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic        wr;
        logic        er;
        logic [4:0]  idx;
        logic [15:0] data;
        logic [2:0]  zcn;
        int          at;
    } exp_t;

    exp_t sb[$];

    exec_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .idx_x(idx_x), .idx_y(idx_y), .imm(imm), .busy(busy),
        .done(done), .err(err), .reg_idx_a(reg_idx_a),
        .reg_idx_b(reg_idx_b), .reg_data_a(reg_data_a),
        .reg_data_b(reg_data_b), .wr_data(wr_data), .wr_idx(wr_idx),
        .wr_en(wr_en), .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n)
    );

    always #5 clk = ~clk;

    assign reg_data_a = rf[reg_idx_a];
    assign reg_data_b = rf[reg_idx_b];

    initial begin
        for (int i = 0; i < 32; i++) rf[i] <= '0;
        rf[1]  <= 16'hFFFF; rf[2]  <= 16'h0001;
        rf[3]  <= 16'h0003; rf[4]  <= 16'h0005;
        rf[5]  <= 16'h1234; rf[6]  <= 16'h0001;
        rf[7]  <= 16'h0001; rf[8]  <= 16'h8000;
        rf[9]  <= 16'h00F0; rf[10] <= 16'h0F0F;
        rf[11] <= 16'h0003; rf[12] <= 16'hAAAA;
        rf[13] <= 16'h8000; rf[14] <= 16'h0001;
        rf[17] <= 16'h0003; rf[18] <= 16'h00FF;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (wr_en) rf[wr_idx] <= wr_data;
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Monitor: every done or wr_en pulse must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n && (done || wr_en)) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("done", 32'(done), 32'd1);
                check("wr_en", 32'(wr_en), 32'(e.wr));
                check("err", 32'(err), 32'(e.er));
                if (e.wr) begin
                    check("wr_idx", 32'(wr_idx), 32'(e.idx));
                    check("wr_data", 32'(wr_data), 32'(e.data));
                end
                check("flags_zcn", 32'({flag_z, flag_c, flag_n}),
                      32'(e.zcn));
                check("latency", 32'(cyc), 32'(e.at));
            end
        end
    end

    function automatic exp_t mk(input logic wr, input logic er,
                                input logic [4:0] idx,
                                input logic [15:0] data,
                                input logic [2:0] zcn);
        exp_t e;
        e.wr = wr; e.er = er; e.idx = idx;
        e.data = data; e.zcn = zcn; e.at = 0;
        return e;
    endfunction

    function automatic int extra(input logic [3:0] o, input logic [3:0] im);
        return (o == 4'd10 || o == 4'd11) ? int'(im) : 0;
    endfunction

    task automatic send(input logic [3:0] o, input logic [4:0] x,
                        input logic [4:0] y, input logic [3:0] im,
                        input bit push, input exp_t e);
        @(negedge clk);
        start = 1'b1; op = o; idx_x = x; idx_y = y; imm = im;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (push) begin
            e.at = cyc + 2 + extra(o, im);
            sb.push_back(e);
        end
    endtask

    task automatic wait_idle(input int exp_busy);
        int n;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
        check("busy_cycles", 32'(n), 32'(exp_busy));
    endtask

    task automatic run(input logic [3:0] o, input logic [4:0] x,
                       input logic [4:0] y, input logic [3:0] im,
                       input exp_t e);
        send(o, x, y, im, 1'b1, e);
        wait_idle(3 + extra(o, im));
    endtask

    initial begin
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_flags", 32'({flag_z, flag_c, flag_n}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        //        op    x      y      imm    wr   er   idx    data        ZCN
        run(4'd0,  5'd1,  5'd2,  4'd0, mk(1, 0, 5'd1,  16'h0000, 3'b110));
        run(4'd2,  5'd3,  5'd4,  4'd0, mk(1, 0, 5'd3,  16'hFFFE, 3'b011));
        run(4'd6,  5'd11, 5'd4,  4'd0, mk(0, 0, 5'd11, 16'h0000, 3'b011));
        run(4'd1,  5'd6,  5'd7,  4'd0, mk(1, 0, 5'd6,  16'h0003, 3'b000));
        run(4'd11, 5'd5,  5'd0,  4'd4, mk(1, 0, 5'd5,  16'h2340, 3'b010));
        run(4'd10, 5'd9,  5'd0,  4'd4, mk(1, 0, 5'd9,  16'h000F, 3'b000));
        run(4'd11, 5'd8,  5'd0,  4'd1, mk(1, 0, 5'd8,  16'h0000, 3'b110));
        run(4'd7,  5'd16, 5'd5,  4'd0, mk(1, 0, 5'd16, 16'h2340, 3'b110));
        run(4'd10, 5'd10, 5'd0,  4'd0, mk(1, 0, 5'd10, 16'h0F0F, 3'b000));
        run(4'd5,  5'd12, 5'd12, 4'd0, mk(1, 0, 5'd12, 16'h0000, 3'b100));
        run(4'd4,  5'd13, 5'd14, 4'd0, mk(1, 0, 5'd13, 16'h8001, 3'b001));
        run(4'd8,  5'd1,  5'd0,  4'd0, mk(1, 0, 5'd1,  16'h0001, 3'b000));
        run(4'd9,  5'd15, 5'd0,  4'd0, mk(1, 0, 5'd15, 16'hFFFF, 3'b011));
        run(4'd13, 5'd2,  5'd2,  4'd0, mk(0, 1, 5'd2,  16'h0000, 3'b011));
        run(4'd3,  5'd10, 5'd9,  4'd0, mk(1, 0, 5'd10, 16'h000F, 3'b000));
        check("rf3_after_sub", 32'(rf[3]), 32'h0000FFFE);
        check("rf11_cmp_unwritten", 32'(rf[11]), 32'h3);
        check("rf2_illegal_unwritten", 32'(rf[2]), 32'h1);

        // ADD presented mid-shift must be ignored
        send(4'd11, 5'd17, 5'd0, 4'd3, 1'b1,
             mk(1, 0, 5'd17, 16'h0018, 3'b000));
        fork
            wait_idle(6);
            begin
                repeat (4) @(posedge clk);
                #2;
                start = 1'b1; op = 4'd0; idx_x = 5'd17; idx_y = 5'd17;
                @(posedge clk);
                #1;
                start = 1'b0;
            end
        join
        repeat (4) @(negedge clk);
        check("rf17_shift_only", 32'(rf[17]), 32'h0018);

        // Reset in the middle of a long shift drops the command
        send(4'd11, 5'd18, 5'd0, 4'd8, 1'b0,
             mk(1, 0, 5'd18, 16'h0000, 3'b000));
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_wr_en", 32'(wr_en), 32'd0);
        check("mid_rst_flags", 32'({flag_z, flag_c, flag_n}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("rf18_unwritten", 32'(rf[18]), 32'h00FF);
        run(4'd0, 5'd18, 5'd2, 4'd0, mk(1, 0, 5'd18, 16'h0100, 3'b000));
        repeat (3) @(negedge clk);
        check("rf18_after_add", 32'(rf[18]), 32'h0100);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
